// File: rtl/fb_pixel_unpacker_if.sv
// Frame RAM read port and pixel stream shared by the unpacker (master)
// and its memory/sink neighbours (slave).
interface fb_pixel_unpacker_if #(
  parameter int WORD_W = 32,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_sof;
  logic              pix_eof;

  modport master (
    output mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eof,
    input  mem_data, pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eof,
    output mem_data, pix_ready
  );
endinterface

// File: rtl/fb_pixel_unpacker.sv
// Streams packed frame-RAM words through a 2-entry word buffer and emits one
// pixel per transfer, tagging the first and last pixel of each frame.
module fb_pixel_unpacker #(
  parameter int WORD_W      = 32,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 17,
  parameter int FRAME_WORDS = 76800,
  parameter int MSB_FIRST   = 0
) (
  input  logic                pixclk,
  input  logic                reset,
  input  logic                frame_sync,
  fb_pixel_unpacker_if.master bus
);
  localparam int PPW    = WORD_W / PIX_W;
  localparam int LANE_W = $clog2(PPW);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPW - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [WORD_W-1:0] fifo_word [2];
  logic [1:0]        fifo_first;
  logic [1:0]        fifo_last;
  logic              head;
  logic [1:0]        count;
  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] addr;
  logic              active;
  logic              inflight;
  logic              inflight_first;
  logic              inflight_last;

  logic [1:0]        occupancy;
  logic              issue;
  logic              has_word;
  logic              xfer;
  logic              pop;
  logic              wr_ptr;
  logic [WORD_W-1:0] head_word;
  logic [LANE_W-1:0] sel;

  // active keeps mem_rd low until the first clock edge after reset release
  assign occupancy = count + {1'b0, inflight};
  assign issue     = active && (occupancy < 2'd2) && !frame_sync;
  assign has_word  = (count != 2'd0);
  assign xfer      = has_word && bus.pix_ready;
  assign pop       = xfer && (lane == LAST_LANE);
  assign wr_ptr    = head ^ count[0];

  assign head_word = fifo_word[head];
  assign sel       = (MSB_FIRST != 0) ? (LAST_LANE - lane) : lane;

  assign bus.mem_rd    = issue;
  assign bus.mem_addr  = addr;
  assign bus.pix_valid = has_word;
  assign bus.pix_data  = head_word[int'(sel) * PIX_W +: PIX_W];
  assign bus.pix_sof   = has_word && fifo_first[head] && (lane == '0);
  assign bus.pix_eof   = has_word && fifo_last[head] && (lane == LAST_LANE);

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      active         <= 1'b0;
      addr           <= '0;
      inflight       <= 1'b0;
      inflight_first <= 1'b0;
      inflight_last  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (frame_sync) begin
        addr     <= '0;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_first <= (addr == '0);
          inflight_last  <= (addr == LAST_ADDR);
          addr           <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        end
      end
    end
  end

  // A frame_sync flush drops both buffered words and the word returning this cycle
  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      fifo_word[0] <= '0;
      fifo_word[1] <= '0;
      fifo_first   <= '0;
      fifo_last    <= '0;
      head         <= 1'b0;
      count        <= '0;
      lane         <= '0;
    end else if (frame_sync) begin
      head  <= 1'b0;
      count <= '0;
      lane  <= '0;
    end else begin
      if (inflight) begin
        fifo_word[wr_ptr]  <= bus.mem_data;
        fifo_first[wr_ptr] <= inflight_first;
        fifo_last[wr_ptr]  <= inflight_last;
      end
      if (xfer) begin
        lane <= pop ? '0 : lane + 1'b1;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_fb_pixel_unpacker.sv
// Scoreboard bench for fb_pixel_unpacker: three configurations (byte LSB-first
// with a 4-word frame, byte MSB-first, 16-bit lanes in 64-bit words).
module tb_fb_pixel_unpacker;
  logic pixclk     = 1'b0;
  logic reset      = 1'b1;
  logic frame_sync = 1'b0;
  int   errors     = 0;
  int   checks     = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
  } pix_t;

  pix_t sb[$];

  always #5 pixclk = ~pixclk;

  fb_pixel_unpacker_if #(.WORD_W(32), .PIX_W(8),  .ADDR_W(3)) ifa ();
  fb_pixel_unpacker_if #(.WORD_W(32), .PIX_W(8),  .ADDR_W(2)) ifb ();
  fb_pixel_unpacker_if #(.WORD_W(64), .PIX_W(16), .ADDR_W(2)) ifc ();

  fb_pixel_unpacker #(.WORD_W(32), .PIX_W(8), .ADDR_W(3), .FRAME_WORDS(4), .MSB_FIRST(0))
    dut_a (.pixclk(pixclk), .reset(reset), .frame_sync(frame_sync), .bus(ifa.master));
  fb_pixel_unpacker #(.WORD_W(32), .PIX_W(8), .ADDR_W(2), .FRAME_WORDS(4), .MSB_FIRST(1))
    dut_b (.pixclk(pixclk), .reset(reset), .frame_sync(frame_sync), .bus(ifb.master));
  fb_pixel_unpacker #(.WORD_W(64), .PIX_W(16), .ADDR_W(2), .FRAME_WORDS(3), .MSB_FIRST(0))
    dut_c (.pixclk(pixclk), .reset(reset), .frame_sync(frame_sync), .bus(ifc.master));

  function automatic logic [31:0] word_a(input logic [2:0] n);
    logic [7:0] b;
    b = 8'(4 * int'(n));
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] word_b(input logic [1:0] n);
    return 32'h44332211 + 32'(n) * 32'h44444444;
  endfunction

  function automatic logic [63:0] word_c(input logic [1:0] n);
    logic [15:0] b;
    b = 16'hA000 + 16'(4 * int'(n));
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Synchronous-read frame RAMs; idle cycles return a poison pattern
  always_ff @(posedge pixclk) begin
    ifa.mem_data <= ifa.mem_rd ? word_a(ifa.mem_addr) : 32'hFFFFFFFF;
    ifb.mem_data <= ifb.mem_rd ? word_b(ifb.mem_addr) : 32'h5A5A5A5A;
    ifc.mem_data <= ifc.mem_rd ? word_c(ifc.mem_addr) : 64'hFFFFFFFFFFFFFFFF;
  end

  function automatic pix_t exp_a(input int k);
    pix_t p;
    p.data = 16'(k % 16);
    p.sof  = (k % 16) == 0;
    p.eof  = (k % 16) == 15;
    return p;
  endfunction

  function automatic pix_t exp_b(input int k);
    pix_t        p;
    logic [31:0] w;
    int          l;
    w      = word_b(2'((k % 16) / 4));
    l      = k % 4;
    p.data = {8'h00, w[(3 - l) * 8 +: 8]};
    p.sof  = (k % 16) == 0;
    p.eof  = (k % 16) == 15;
    return p;
  endfunction

  function automatic pix_t exp_c(input int k);
    pix_t p;
    p.data = 16'hA000 + 16'(k % 12);
    p.sof  = (k % 12) == 0;
    p.eof  = (k % 12) == 11;
    return p;
  endfunction

  task automatic do_reset(input logic rdy);
    reset         = 1'b0;
    frame_sync    = 1'b0;
    ifa.pix_ready = rdy;
    ifb.pix_ready = rdy;
    ifc.pix_ready = rdy;
    repeat (2) @(negedge pixclk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    ifa.pix_ready = 1'b0;
    ifb.pix_ready = 1'b0;
    ifc.pix_ready = 1'b0;
    #1 reset = 1'b0;
    #2;
    checks++;
    if (ifa.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd got=%b want=0", ifa.mem_rd); end
    checks++;
    if (ifa.mem_addr !== 3'd0) begin errors++; $display("[TB] FAIL reset_mem_addr got=%0d want=0", ifa.mem_addr); end
    checks++;
    if (ifa.pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_valid got=%b want=0", ifa.pix_valid); end
    checks++;
    if ({ifa.pix_data, ifa.pix_sof, ifa.pix_eof} !== 10'd0) begin
      errors++; $display("[TB] FAIL reset_pix_outputs got=%h/%b/%b want=0/0/0", ifa.pix_data, ifa.pix_sof, ifa.pix_eof);
    end
    checks++;
    if ({ifc.pix_valid, ifc.pix_data, ifc.mem_rd} !== 18'd0) begin
      errors++; $display("[TB] FAIL reset_wide_outputs got=%b/%h/%b want=0/0/0", ifc.pix_valid, ifc.pix_data, ifc.mem_rd);
    end
  endtask

  task automatic test_streaming();
    pix_t       act;
    pix_t       exp;
    logic [2:0] exp_addr = 3'd0;
    do_reset(1'b1);
    sb.delete();
    for (int k = 0; k < 40; k++) sb.push_back(exp_a(k));
    for (int c = 0; c < 42; c++) begin
      @(negedge pixclk);
      if (c < 2) begin
        checks++;
        if (ifa.mem_rd !== 1'b1 || ifa.mem_addr !== 3'(c) || ifa.pix_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL startup_cycle%0d got rd=%b addr=%0d valid=%b want rd=1 addr=%0d valid=0",
                             c, ifa.mem_rd, ifa.mem_addr, ifa.pix_valid, c);
        end
      end
      if (ifa.mem_rd) begin
        checks++;
        if (ifa.mem_addr !== exp_addr) begin
          errors++; $display("[TB] FAIL stream_addr got=%0d want=%0d", ifa.mem_addr, exp_addr);
        end
        exp_addr = (exp_addr == 3'd3) ? 3'd0 : exp_addr + 3'd1;
      end
      if (c >= 2) begin
        checks++;
        if (!ifa.pix_valid) begin
          errors++; $display("[TB] FAIL stream_bubble cycle=%0d got valid=0 want valid=1", c);
        end else if (sb.size() != 0) begin
          exp = sb.pop_front();
          act = {8'h00, ifa.pix_data, ifa.pix_sof, ifa.pix_eof};
          if (act !== exp) begin
            errors++; $display("[TB] FAIL stream_pixel got=%h want=%h", act, exp);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL stream_count got_left=%0d want_left=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    pix_t act;
    pix_t exp;
    pix_t held = '0;
    logic stalled = 1'b0;
    logic rdy;
    int   issued = 0;
    int   moved  = 0;
    do_reset(1'b0);
    sb.delete();
    for (int k = 0; k < 1100; k++) sb.push_back(exp_a(k));
    for (int c = 0; c < 1000; c++) begin
      @(negedge pixclk);
      act = {8'h00, ifa.pix_data, ifa.pix_sof, ifa.pix_eof};
      checks++;
      if (issued - moved / 4 > 2) begin
        errors++; $display("[TB] FAIL bp_occupancy got=%0d want<=2", issued - moved / 4);
      end
      if (stalled) begin
        checks++;
        if (!ifa.pix_valid || act !== held) begin
          errors++; $display("[TB] FAIL bp_stall_hold got=%b/%h want=1/%h", ifa.pix_valid, act, held);
        end
      end
      rdy           = 1'($urandom_range(0, 1));
      ifa.pix_ready = rdy;
      if (ifa.mem_rd) issued++;
      stalled = ifa.pix_valid && !rdy;
      held    = act;
      if (ifa.pix_valid && rdy) begin
        exp = sb.pop_front();
        checks++;
        if (act !== exp) begin
          errors++; $display("[TB] FAIL bp_pixel got=%h want=%h", act, exp);
        end
        moved++;
      end
    end
    checks++;
    if (moved < 300) begin errors++; $display("[TB] FAIL bp_progress got=%0d want>=300", moved); end
    ifa.pix_ready = 1'b1;
  endtask

  task automatic test_resync();
    pix_t act;
    pix_t exp;
    logic synced = 1'b0;
    do_reset(1'b1);
    sb.delete();
    for (int k = 0; k < 10; k++) sb.push_back(exp_a(k));
    for (int c = 0; c < 30 && !synced; c++) begin
      @(negedge pixclk);
      if (ifa.pix_valid) begin
        exp = sb.pop_front();
        act = {8'h00, ifa.pix_data, ifa.pix_sof, ifa.pix_eof};
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL resync_pre got=%h want=%h", act, exp); end
        if (sb.size() == 0) begin
          frame_sync = 1'b1;
          synced     = 1'b1;
        end
      end
    end
    checks++;
    if (!synced) begin
      errors++; $display("[TB] FAIL resync_reach got=not_reached want=word2_lane1");
    end else begin
      #1;
      checks++;
      if (ifa.mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL resync_no_read got=%b want=0", ifa.mem_rd); end
      @(negedge pixclk);
      frame_sync = 1'b0;
      #1;
      checks++;
      if (ifa.pix_valid !== 1'b0 || ifa.mem_rd !== 1'b1 || ifa.mem_addr !== 3'd0) begin
        errors++; $display("[TB] FAIL resync_s1 got valid=%b rd=%b addr=%0d want 0/1/0", ifa.pix_valid, ifa.mem_rd, ifa.mem_addr);
      end
      @(negedge pixclk);
      checks++;
      if (ifa.pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL resync_s2 got valid=%b want=0", ifa.pix_valid); end
      sb.delete();
      for (int k = 0; k < 20; k++) sb.push_back(exp_a(k));
      for (int c = 0; c < 20; c++) begin
        @(negedge pixclk);
        checks++;
        if (!ifa.pix_valid) begin
          errors++; $display("[TB] FAIL resync_post cycle=s+%0d got valid=0 want valid=1", c + 3);
        end else begin
          exp = sb.pop_front();
          act = {8'h00, ifa.pix_data, ifa.pix_sof, ifa.pix_eof};
          if (act !== exp) begin errors++; $display("[TB] FAIL resync_post got=%h want=%h", act, exp); end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (15) @(negedge pixclk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ifa.mem_rd, ifa.mem_addr, ifa.pix_valid, ifa.pix_data, ifa.pix_sof, ifa.pix_eof} !== 15'd0) begin
      errors++; $display("[TB] FAIL async_reset got rd=%b addr=%0d valid=%b data=%h sof=%b eof=%b want all 0",
                         ifa.mem_rd, ifa.mem_addr, ifa.pix_valid, ifa.pix_data, ifa.pix_sof, ifa.pix_eof);
    end
    @(negedge pixclk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pixclk);
      checks++;
      if (c < 2 && (ifa.mem_rd !== 1'b1 || ifa.mem_addr !== 3'(c))) begin
        errors++; $display("[TB] FAIL restart_cycle%0d got rd=%b addr=%0d want rd=1 addr=%0d", c, ifa.mem_rd, ifa.mem_addr, c);
      end
      if (c == 2 && {ifa.pix_valid, ifa.pix_data, ifa.pix_sof} !== {1'b1, 8'h00, 1'b1}) begin
        errors++; $display("[TB] FAIL restart_first got valid=%b data=%h sof=%b want 1/00/1", ifa.pix_valid, ifa.pix_data, ifa.pix_sof);
      end
    end
  endtask

  task automatic test_lane_order_msb();
    pix_t act;
    pix_t exp;
    do_reset(1'b1);
    sb.delete();
    sb.push_back('{data: 16'h0044, sof: 1'b1, eof: 1'b0});
    sb.push_back('{data: 16'h0033, sof: 1'b0, eof: 1'b0});
    sb.push_back('{data: 16'h0022, sof: 1'b0, eof: 1'b0});
    sb.push_back('{data: 16'h0011, sof: 1'b0, eof: 1'b0});
    for (int k = 4; k < 20; k++) sb.push_back(exp_b(k));
    for (int c = 0; c < 24; c++) begin
      @(negedge pixclk);
      if (ifb.pix_valid && sb.size() != 0) begin
        exp = sb.pop_front();
        act = {8'h00, ifb.pix_data, ifb.pix_sof, ifb.pix_eof};
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL msb_lane got=%h want=%h", act, exp); end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL msb_count got_left=%0d want_left=0", sb.size()); end
  endtask

  task automatic test_wide_lanes();
    pix_t act;
    pix_t exp;
    do_reset(1'b1);
    sb.delete();
    for (int k = 0; k < 16; k++) sb.push_back(exp_c(k));
    for (int c = 0; c < 22; c++) begin
      @(negedge pixclk);
      if (ifc.pix_valid && sb.size() != 0) begin
        exp = sb.pop_front();
        act = {ifc.pix_data, ifc.pix_sof, ifc.pix_eof};
        checks++;
        if (act !== exp) begin errors++; $display("[TB] FAIL wide_lane got=%h want=%h", act, exp); end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL wide_count got_left=%0d want_left=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_resync();
    test_async_reset();
    test_lane_order_msb();
    test_wide_lanes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
